// File: rtl/zmips_pkg.sv
// Shared definitions for the zmips data-memory slice: word/offset widths and
// the posted-write-buffer entry layout.
package zmips_pkg;

    localparam int WORD_W     = 32;
    localparam int OFF_W      = 2;
    localparam int IDX_W      = 16;
    localparam int WBUF_DEPTH = 2;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [WORD_W-1:0] data;
    } wbuf_entry_t;

endpackage

// File: rtl/zmips_dmem_wbuf.sv
// Two-entry posted write buffer for zmips_dmem: FIFO of {index, data} with a
// youngest-first match lookup used to bypass reads of not-yet-retired stores.
module zmips_dmem_wbuf
    import zmips_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [IDX_W-1:0]  push_idx,
    input  logic [WORD_W-1:0] push_data,
    input  logic              pop,
    input  logic [IDX_W-1:0]  lookup_idx,
    output logic              hit,
    output logic [WORD_W-1:0] hit_data,
    output logic [IDX_W-1:0]  head_idx,
    output logic [WORD_W-1:0] head_data,
    output logic [1:0]        cnt
);

    wbuf_entry_t slot_r [WBUF_DEPTH];
    logic        wr_ptr_r;
    logic        rd_ptr_r;
    logic [1:0]  cnt_r;
    logic        pop_ok_s;
    logic        push_ok_s;
    wbuf_entry_t young_s;
    wbuf_entry_t old_s;

    // A push into a full buffer is only accepted when the head retires on the same edge.
    assign pop_ok_s  = pop && (cnt_r != 2'd0);
    assign push_ok_s = push && ((cnt_r != 2'd2) || pop_ok_s);

    // FIFO storage, pointers and occupancy, updated on the falling edge.
    always_ff @(negedge clk) begin
        if (rst) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            cnt_r    <= 2'd0;
        end else begin
            if (push_ok_s) begin
                slot_r[wr_ptr_r] <= '{idx: push_idx, data: push_data};
                wr_ptr_r         <= ~wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   cnt_r <= cnt_r + 2'd1;
                2'b01:   cnt_r <= cnt_r - 2'd1;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // The youngest entry always sits just behind the write pointer.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        young_s  = slot_r[~wr_ptr_r];
        old_s    = slot_r[rd_ptr_r];
        if ((cnt_r != 2'd0) && (young_s.idx == lookup_idx)) begin
            hit      = 1'b1;
            hit_data = young_s.data;
        end else if ((cnt_r == 2'd2) && (old_s.idx == lookup_idx)) begin
            hit      = 1'b1;
            hit_data = old_s.data;
        end else begin
            hit      = 1'b0;
            hit_data = '0;
        end
    end

    assign head_idx  = slot_r[rd_ptr_r].idx;
    assign head_data = slot_r[rd_ptr_r].data;
    assign cnt       = cnt_r;

endmodule

// File: rtl/zmips_dmem.sv
// zmips data memory: word array with half-cycle read latency on a shared bus.
// Define ZMIPS_DMEM_WBUF_EN to add the 2-entry posted write buffer.
module zmips_dmem
    import zmips_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] d_addr,
    inout  wire  [31:0] d_data,
    input  logic        d_wr,
    input  logic        d_rd,
    output logic        err,
    output logic [1:0]  wbuf_cnt
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] MEM_BYTES = 32'(DEPTH_WORDS) << 2;

    logic [WORD_W-1:0] mem_r [DEPTH_WORDS];
    logic [31:0]       off_s;
    logic              legal_s;
    logic              bad_s;
    logic              wr_ok_s;
    logic              rd_ok_s;
    logic [AW-1:0]     idx_s;
    logic [WORD_W-1:0] rd_word_s;
    logic [WORD_W-1:0] rd_data_r;
    logic              rd_valid_r;
    logic              err_r;

    // Offset compare avoids overflow of BASE_ADDR + size near the top of the map.
    assign off_s   = d_addr - BASE_ADDR;
    assign legal_s = (d_addr[OFF_W-1:0] == 2'b00) && (d_addr >= BASE_ADDR)
                     && (off_s < MEM_BYTES) && !(d_rd && d_wr);
    assign idx_s   = off_s[AW+1:2];
    assign bad_s   = (d_rd || d_wr) && !legal_s;
    assign wr_ok_s = d_wr && legal_s;
    assign rd_ok_s = d_rd && legal_s;

`ifdef ZMIPS_DMEM_WBUF_EN
    logic              hit_s;
    logic [WORD_W-1:0] hit_data_s;
    logic [IDX_W-1:0]  head_idx_s;
    logic [WORD_W-1:0] head_data_s;
    logic [1:0]        wbuf_cnt_s;
    logic              drain_s;
    logic              head_fit_s;

    // Retire when the bus is idle, or make room for a store into a full buffer.
    assign drain_s    = !rst && (wbuf_cnt_s != 2'd0)
                        && ((!d_rd && !d_wr) || ((wbuf_cnt_s == 2'd2) && wr_ok_s));
    assign head_fit_s = ({1'b0, head_idx_s} < (IDX_W+1)'(DEPTH_WORDS));

    zmips_dmem_wbuf u_wbuf (
        .clk        (clk),
        .rst        (rst),
        .push       (wr_ok_s),
        .push_idx   (IDX_W'(idx_s)),
        .push_data  (d_data),
        .pop        (drain_s),
        .lookup_idx (IDX_W'(idx_s)),
        .hit        (hit_s),
        .hit_data   (hit_data_s),
        .head_idx   (head_idx_s),
        .head_data  (head_data_s),
        .cnt        (wbuf_cnt_s)
    );

    assign rd_word_s = hit_s ? hit_data_s : mem_r[idx_s];
    assign wbuf_cnt  = wbuf_cnt_s;

    // Array write port: retires the buffer head on the falling edge.
    always_ff @(negedge clk) begin
        if (drain_s && head_fit_s) begin
            mem_r[head_idx_s[AW-1:0]] <= head_data_s;
        end
    end
`else
    assign rd_word_s = mem_r[idx_s];
    assign wbuf_cnt  = 2'b00;

    // Array write port: legal stores land directly on the falling edge.
    always_ff @(negedge clk) begin
        if (!rst && wr_ok_s) begin
            mem_r[idx_s] <= d_data;
        end
    end
`endif

    // Read-data register: captures the addressed word (or 0 if illegal) on the rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_r <= 1'b0;
            rd_data_r  <= '0;
        end else if (d_rd) begin
            rd_valid_r <= 1'b1;
            rd_data_r  <= rd_ok_s ? rd_word_s : 32'h0000_0000;
        end else begin
            rd_valid_r <= 1'b0;
            rd_data_r  <= rd_data_r;
        end
    end

    // Sticky access-error flag, cleared only by reset.
    always_ff @(negedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (bad_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    // Release the bus combinationally as soon as the load ends or reset asserts.
    assign d_data = (d_rd && !rst && rd_valid_r) ? rd_data_r : 32'bz;
    assign err    = err_r;

endmodule

// File: doc/zmips_dmem.md
ZMIPS_DMEM -- requirements
Module: zmips_dmem

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, meaning array size in 32-bit words (power of two, 16..65536).
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, meaning byte address of word 0.
REQ-003 clk  input  1  core clock.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 d_addr  input  32  byte address from core MEM stage.
REQ-006 d_data  inout  32  data bus; driven by this block only during read service, high-Z otherwise.
REQ-007 d_wr  input  1  store request.
REQ-008 d_rd  input  1  load request.
REQ-009 err  output  1  sticky access-error flag.
REQ-010 wbuf_cnt  output  2  write-buffer occupancy, 0..2 (constant 0 when buffer compiled out).

Function
REQ-011 The block SHALL use one clock, clk; state updates on negedge clk except the read-data register, which loads on posedge clk.
REQ-012 An access SHALL be legal only when d_addr[1:0]==0, BASE_ADDR <= d_addr < BASE_ADDR+4*DEPTH_WORDS, and not (d_rd and d_wr).
REQ-013 Illegal access SHALL set err at the next negedge, perform no array/buffer update, and drive d_data=0 for an illegal read.
REQ-014 Read: index sampled at posedge clk while d_rd=1; d_data driven from that posedge until d_rd falls or the next posedge, giving half-cycle latency so data is stable before the core's negedge capture.
REQ-015 Read data SHALL come from the youngest write-buffer entry with matching index, else from the array.
REQ-016 d_data SHALL be high-Z whenever d_rd=0 or rst=1.
REQ-017 Write (buffer enabled): legal store enqueued into 2-entry FIFO {index, data} at negedge.
REQ-018 Drain: head entry written to array at negedge when d_rd=0 and d_wr=0 (idle), or forced when buffer full and d_wr=1 (dequeue and enqueue same edge, occupancy stays 2).
REQ-019 No drain SHALL occur in a cycle with d_rd=1; array read port has priority.
REQ-020 Buffer overflow SHALL be impossible; occupancy never exceeds 2; index pointers wrap modulo 2.
REQ-021 Two buffered stores to the same index SHALL both retire in order; array ends with the younger value.
REQ-022 Array contents SHALL be undefined after power-up and unaffected by rst.

Reset
REQ-023 rst sampled at negedge: err=0, wbuf_cnt=0, FIFO pointers cleared, pending buffered stores discarded, d_data high-Z.
REQ-024 rst asserted mid-read SHALL release d_data immediately (combinational gating) and abort the read.

Configuration
REQ-025 Macro ZMIPS_DMEM_WBUF_EN defined: posted write buffer per REQ-017..021 present.
REQ-026 Macro undefined: legal store writes the array directly at the negedge of its cycle; no bypass logic; wbuf_cnt tied 0.

Structure
REQ-027 Shared package zmips_pkg SHALL hold word width (32), byte-offset width (2), and the FIFO entry type {index, data}.
REQ-028 One sub-module, zmips_dmem_wbuf, SHALL implement the 2-entry FIFO with match/bypass lookup; instantiated only under ZMIPS_DMEM_WBUF_EN.

Verification
REQ-029 SW 32'hDEAD_BEEF to 0x10, next cycle LW 0x10 -> d_data=32'hDEAD_BEEF via bypass, wbuf_cnt=1.
REQ-030 SW 0x20=1, SW 0x20=2, SW 0x24=3 back-to-back, then 3 idle cycles -> wbuf_cnt 1,2,2,1,0,0; LW 0x20 returns 2, LW 0x24 returns 3.
REQ-031 LW 0x2 (misaligned) -> d_data=0, err=1 at next negedge, array unchanged; err stays 1 until rst.
REQ-032 d_rd=d_wr=1 at 0x8 -> err=1, no write, wbuf_cnt unchanged.
REQ-033 Two buffered stores pending, rst pulsed one cycle -> wbuf_cnt=0, LW of those addresses returns prior array values.
REQ-034 Macro undefined: SW 0x40=32'h1234_5678, next-cycle LW 0x40 -> 32'h1234_5678, wbuf_cnt always 0.
